// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit 7-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  en;
    } disp_buf_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load port between game/score logic (master) and the scan controller (slave).
interface seg_scan_ctrl_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame_done;

    modport master (
        output load, value, dots, digit_en,
        input  pending, frame_done
    );

    modport slave (
        input  load, value, dots, digit_en,
        output pending, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl_hex2seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex2seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin anode scanner with per-slot blanking guard and frame-aligned double buffer.
// Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_ctrl_if.slave    bus,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);
    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_buf_t        act_q, pend_q, load_buf;
    logic             pending_q;
    logic             boundary;
    logic [3:0]       suppress;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign load_buf    = {bus.value, bus.dots, bus.digit_en};
    assign nibble      = act_q.value[{idx_q, 2'b00} +: 4];
    assign bus.pending = pending_q;

    hex2seg u_hex2seg (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit is a leading zero only if every digit to its left is one too.
    always_comb begin
        suppress    = 4'b0000;
        suppress[3] = (act_q.value[15:12] == 4'h0);
        suppress[2] = suppress[3] && (act_q.value[11:8] == 4'h0);
        suppress[1] = suppress[2] && (act_q.value[7:4] == 4'h0);
    end
`else
    assign suppress = 4'b0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        boundary = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) state_d = DRIVE;
            end
            DRIVE: begin
                if (act_q.en[idx_q] && !suppress[idx_q]) begin
                    an_d  = ~(4'b0001 << idx_q);
                    seg_d = dec_seg;
                    dp_d  = ~act_q.dots[idx_q];
                end
                if (cnt_q == SLOT_LAST) begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // A load landing on the boundary cycle bypasses the pending buffer entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q          <= '0;
            pend_q         <= '0;
            pending_q      <= 1'b0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp             <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            an             <= an_d;
            seg            <= seg_d;
            dp             <= dp_d;
            bus.frame_done <= boundary;
            if (bus.load) begin
                if (boundary) begin
                    act_q     <= load_buf;
                    pending_q <= 1'b0;
                end else begin
                    pend_q    <= load_buf;
                    pending_q <= 1'b1;
                end
            end else if (boundary && pending_q) begin
                act_q     <= pend_q;
                pending_q <= 1'b0;
            end
        end
    end

endmodule
